// File: rtl/pc_sequencer.sv
// Fetch/issue sequencer for the 8-bit program counter: fetches one- or two-byte
// instructions over req/ack, hands them to decode over valid/ready, then advances or loads the PC.
module pc_sequencer #(
   parameter int unsigned ACK_TIMEOUT = 16
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       start,
   input  logic       halt_req,
   input  logic [7:0] pc_value,
   output logic       pc_en,
   output logic       pc_write,
   output logic [7:0] pc_write_value,
   output logic       pc_increment,
   output logic       pc_inc_mode,
   output logic       pc_reset,
   output logic       mem_req,
   output logic [7:0] mem_addr,
   input  logic       mem_ack,
   input  logic [7:0] mem_rdata,
   output logic       instr_valid,
   output logic [7:0] instr_op,
   output logic [7:0] instr_imm,
   input  logic       instr_ready,
   input  logic       branch_taken,
   input  logic [7:0] branch_target,
   output logic       halted,
   output logic       err
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_FETCH_OP,
      S_FETCH_IMM,
      S_ISSUE,
      S_HALTED,
      S_ERROR
   } state_t;

   // Counter value seen in the last request cycle that may still accept mem_ack.
   localparam logic [7:0] LAST_WAIT = 8'(ACK_TIMEOUT - 1);

   state_t     state_q, state_d;
   logic [7:0] instr_op_q, instr_op_d;
   logic [7:0] instr_imm_q, instr_imm_d;
   logic [7:0] wait_cnt_q, wait_cnt_d;
   logic       halt_pend_q, halt_pend_d;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= S_IDLE;
         instr_op_q  <= 8'h00;
         instr_imm_q <= 8'h00;
         wait_cnt_q  <= 8'h00;
         halt_pend_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         instr_op_q  <= instr_op_d;
         instr_imm_q <= instr_imm_d;
         wait_cnt_q  <= wait_cnt_d;
         halt_pend_q <= halt_pend_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      instr_op_d  = instr_op_q;
      instr_imm_d = instr_imm_q;
      wait_cnt_d  = wait_cnt_q;
      halt_pend_d = halt_pend_q;
      unique case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d    = S_FETCH_OP;
               wait_cnt_d = 8'h00;
            end
         end
         S_FETCH_OP: begin
            if (halt_req) halt_pend_d = 1'b1;
            if (mem_ack) begin
               instr_op_d = mem_rdata;
               wait_cnt_d = 8'h00;
               if (mem_rdata[7]) begin
                  state_d = S_FETCH_IMM;
               end else begin
                  instr_imm_d = 8'h00;
                  state_d     = S_ISSUE;
               end
            end else if (wait_cnt_q == LAST_WAIT) begin
               state_d = S_ERROR;
            end else begin
               wait_cnt_d = wait_cnt_q + 8'd1;
            end
         end
         S_FETCH_IMM: begin
            if (halt_req) halt_pend_d = 1'b1;
            if (mem_ack) begin
               instr_imm_d = mem_rdata;
               wait_cnt_d  = 8'h00;
               state_d     = S_ISSUE;
            end else if (wait_cnt_q == LAST_WAIT) begin
               state_d = S_ERROR;
            end else begin
               wait_cnt_d = wait_cnt_q + 8'd1;
            end
         end
         S_ISSUE: begin
            if (instr_ready) begin
               if (halt_pend_q || halt_req) begin
                  state_d     = S_HALTED;
                  halt_pend_d = 1'b0;
               end else begin
                  state_d    = S_FETCH_OP;
                  wait_cnt_d = 8'h00;
               end
            end else if (halt_req) begin
               halt_pend_d = 1'b1;
            end
         end
         S_HALTED: begin
            if (start) begin
               state_d    = S_FETCH_OP;
               wait_cnt_d = 8'h00;
            end
         end
         S_ERROR: begin
            halt_pend_d = 1'b0;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // PC strobes in ISSUE follow the decode handshake combinationally so the
   // next FETCH_OP already sees the updated pc_value.
   always_comb begin
      pc_en          = 1'b0;
      pc_write       = 1'b0;
      pc_write_value = 8'h00;
      pc_increment   = 1'b0;
      pc_inc_mode    = 1'b0;
      pc_reset       = 1'b0;
      mem_req        = 1'b0;
      mem_addr       = 8'h00;
      instr_valid    = 1'b0;
      halted         = 1'b0;
      err            = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if (start && reset) begin
               pc_en    = 1'b1;
               pc_reset = 1'b1;
            end
         end
         S_FETCH_OP: begin
            mem_req  = 1'b1;
            mem_addr = pc_value;
         end
         S_FETCH_IMM: begin
            mem_req  = 1'b1;
            mem_addr = pc_value + 8'd1;
         end
         S_ISSUE: begin
            instr_valid = 1'b1;
            if (instr_ready) begin
               pc_en = 1'b1;
               if (branch_taken) begin
                  pc_write       = 1'b1;
                  pc_write_value = branch_target;
               end else begin
                  pc_increment = 1'b1;
                  pc_inc_mode  = instr_op_q[7];
               end
            end
         end
         S_HALTED: halted = 1'b1;
         S_ERROR:  err    = 1'b1;
         default: begin
            err = 1'b0;
         end
      endcase
   end

   assign instr_op  = (state_q == S_ERROR) ? 8'h00 : instr_op_q;
   assign instr_imm = (state_q == S_ERROR) ? 8'h00 : instr_imm_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: a directed walk through fetch, issue, branch, halt, timeout and
// async reset, followed by a randomized run, all checked against a transaction-level model.
module tb_pc_sequencer;

   localparam int TO = 4;

   localparam int ID_EN = 0, ID_WR = 1, ID_WV = 2, ID_INC = 3, ID_MODE = 4, ID_RST = 5,
                  ID_REQ = 6, ID_ADDR = 7, ID_VALID = 8, ID_OP = 9, ID_IMM = 10,
                  ID_HALTED = 11, ID_ERR = 12;

   logic       clk;
   logic       reset;
   logic       start;
   logic       halt_req;
   logic [7:0] pc_value;
   logic       pc_en;
   logic       pc_write;
   logic [7:0] pc_write_value;
   logic       pc_increment;
   logic       pc_inc_mode;
   logic       pc_reset;
   logic       mem_req;
   logic [7:0] mem_addr;
   logic       mem_ack;
   logic [7:0] mem_rdata;
   logic       instr_valid;
   logic [7:0] instr_op;
   logic [7:0] instr_imm;
   logic       instr_ready;
   logic       branch_taken;
   logic [7:0] branch_target;
   logic       halted;
   logic       err;

   logic [7:0] mem [256];
   logic [7:0] pcReg = 8'h00;
   logic [7:0] pcNext = 8'h00;

   int totalCount = 0;
   int badCount = 0;

   // Model of the sequencer in terms of "bytes fetched of the current instruction".
   bit         mIdle = 1'b1;
   bit         mHalted = 1'b0;
   bit         mErr = 1'b0;
   bit         mBusy = 1'b0;
   bit         mPend = 1'b0;
   int         mGot = 0;
   int         mLen = 0;
   int         mWait = 0;
   logic [7:0] mOp = 8'h00;
   logic [7:0] mImm = 8'h00;

   int         litSig [512];
   logic [7:0] litVal [512];
   int         wrIdx = 0;
   int         rdIdx = 0;
   logic       probe = 1'b0;

   pc_sequencer #(.ACK_TIMEOUT(TO)) dut (
      .clk(clk), .reset(reset), .start(start), .halt_req(halt_req), .pc_value(pc_value),
      .pc_en(pc_en), .pc_write(pc_write), .pc_write_value(pc_write_value),
      .pc_increment(pc_increment), .pc_inc_mode(pc_inc_mode), .pc_reset(pc_reset),
      .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
      .instr_valid(instr_valid), .instr_op(instr_op), .instr_imm(instr_imm),
      .instr_ready(instr_ready), .branch_taken(branch_taken), .branch_target(branch_target),
      .halted(halted), .err(err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   assign pc_value  = pcReg;
   assign mem_rdata = mem[mem_addr];

   // The PC itself lives in the bench and reacts to whatever strobes the sequencer drives.
   always @(posedge clk) pcReg <= pcNext;

   function automatic logic [7:0] sigVal(input int id);
      case (id)
         ID_EN:     return 8'(pc_en);
         ID_WR:     return 8'(pc_write);
         ID_WV:     return pc_write_value;
         ID_INC:    return 8'(pc_increment);
         ID_MODE:   return 8'(pc_inc_mode);
         ID_RST:    return 8'(pc_reset);
         ID_REQ:    return 8'(mem_req);
         ID_ADDR:   return mem_addr;
         ID_VALID:  return 8'(instr_valid);
         ID_OP:     return instr_op;
         ID_IMM:    return instr_imm;
         ID_HALTED: return 8'(halted);
         default:   return 8'(err);
      endcase
   endfunction

   function automatic string sigName(input int id);
      case (id)
         ID_EN:     return "pc_en";
         ID_WR:     return "pc_write";
         ID_WV:     return "pc_write_value";
         ID_INC:    return "pc_increment";
         ID_MODE:   return "pc_inc_mode";
         ID_RST:    return "pc_reset";
         ID_REQ:    return "mem_req";
         ID_ADDR:   return "mem_addr";
         ID_VALID:  return "instr_valid";
         ID_OP:     return "instr_op";
         ID_IMM:    return "instr_imm";
         ID_HALTED: return "halted";
         default:   return "err";
      endcase
   endfunction

   task automatic checkOutput(input string name, input logic [7:0] act, input logic [7:0] exp);
      totalCount++;
      if (act !== exp) begin
         badCount++;
         $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic expectLit(input int id, input logic [7:0] v);
      litSig[wrIdx] = id;
      litVal[wrIdx] = v;
      wrIdx++;
   endtask

   task automatic applyStimulus(input logic s, input logic h, input logic a, input logic r,
                                input logic b, input logic [7:0] t);
      start         = s;
      halt_req      = h;
      mem_ack       = a;
      instr_ready   = r;
      branch_taken  = b;
      branch_target = t;
   endtask

   task automatic stepCycle(input logic s, input logic h, input logic a, input logic r,
                            input logic b, input logic [7:0] t);
      @(posedge clk);
      #1;
      applyStimulus(s, h, a, r, b, t);
   endtask

   // Single checking process: model compare, then literal expectations, then model advance.
   always begin
      bit         fetching, issuing;
      logic       eEn, eWr, eInc, eMode, eRst;
      logic [7:0] eWv, eAddr, b;
      @(negedge clk or posedge probe);
      if (!probe) begin
         if (!reset) begin
            for (int id = 0; id <= ID_ERR; id++) checkOutput(sigName(id), sigVal(id), 8'h00);
            mIdle = 1'b1; mHalted = 1'b0; mErr = 1'b0; mBusy = 1'b0; mPend = 1'b0;
            mGot = 0; mLen = 0; mWait = 0; mOp = 8'h00; mImm = 8'h00;
         end else begin
            issuing  = mBusy && (mLen != 0) && (mGot == mLen);
            fetching = mBusy && !issuing;
            eEn = 1'b0; eWr = 1'b0; eInc = 1'b0; eMode = 1'b0; eRst = 1'b0; eWv = 8'h00;
            eAddr = 8'(int'(pcReg) + mGot);
            if (mIdle && start) begin
               eEn = 1'b1; eRst = 1'b1;
            end else if (issuing && instr_ready) begin
               eEn = 1'b1;
               if (branch_taken) begin
                  eWr = 1'b1; eWv = branch_target;
               end else begin
                  eInc = 1'b1; eMode = mOp[7];
               end
            end
            checkOutput("mem_req", 8'(mem_req), 8'(fetching));
            if (fetching) checkOutput("mem_addr", mem_addr, eAddr);
            checkOutput("instr_valid", 8'(instr_valid), 8'(issuing));
            if (issuing) begin
               checkOutput("instr_op", instr_op, mOp);
               checkOutput("instr_imm", instr_imm, mImm);
            end
            checkOutput("pc_en", 8'(pc_en), 8'(eEn));
            checkOutput("pc_write", 8'(pc_write), 8'(eWr));
            if (eWr) checkOutput("pc_write_value", pc_write_value, eWv);
            checkOutput("pc_increment", 8'(pc_increment), 8'(eInc));
            if (eInc) checkOutput("pc_inc_mode", 8'(pc_inc_mode), 8'(eMode));
            checkOutput("pc_reset", 8'(pc_reset), 8'(eRst));
            checkOutput("halted", 8'(halted), 8'(mHalted));
            checkOutput("err", 8'(err), 8'(mErr));
            if (mErr) begin
               checkOutput("err_mem_addr", mem_addr, 8'h00);
               checkOutput("err_instr_op", instr_op, 8'h00);
               checkOutput("err_instr_imm", instr_imm, 8'h00);
               checkOutput("err_pc_write_value", pc_write_value, 8'h00);
               checkOutput("err_pc_inc_mode", 8'(pc_inc_mode), 8'h00);
            end
         end
      end
      while (rdIdx < wrIdx) begin
         checkOutput({"lit_", sigName(litSig[rdIdx])}, sigVal(litSig[rdIdx]), litVal[rdIdx]);
         rdIdx++;
      end
      if (!probe) begin
         pcNext = pcReg;
         if (pc_en) begin
            if (pc_reset) pcNext = 8'h00;
            else if (pc_write) pcNext = pc_write_value;
            else if (pc_increment) pcNext = pcReg + (pc_inc_mode ? 8'd2 : 8'd1);
         end
         if (reset && !mErr) begin
            issuing  = mBusy && (mLen != 0) && (mGot == mLen);
            fetching = mBusy && !issuing;
            if ((mIdle || mHalted) && start) begin
               mIdle = 1'b0; mHalted = 1'b0; mBusy = 1'b1;
               mGot = 0; mLen = 0; mWait = 0;
            end else if (fetching) begin
               if (halt_req) mPend = 1'b1;
               if (mem_ack) begin
                  b = mem[8'(int'(pcReg) + mGot)];
                  if (mGot == 0) begin
                     mOp  = b;
                     mLen = b[7] ? 2 : 1;
                     if (!b[7]) mImm = 8'h00;
                  end else begin
                     mImm = b;
                  end
                  mGot++;
                  mWait = 0;
               end else begin
                  mWait++;
                  if (mWait == TO) begin
                     mErr = 1'b1; mBusy = 1'b0; mPend = 1'b0;
                  end
               end
            end else if (issuing) begin
               if (instr_ready) begin
                  if (mPend || halt_req) begin
                     mHalted = 1'b1; mBusy = 1'b0; mPend = 1'b0;
                  end else begin
                     mGot = 0; mLen = 0; mWait = 0;
                  end
               end else if (halt_req) begin
                  mPend = 1'b1;
               end
            end
         end
      end
   end

   initial begin
      int errCycles;
      int inReset;
      reset = 1'b0;
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
      for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
      mem[8'h00] = 8'h12; mem[8'h01] = 8'h01; mem[8'h05] = 8'h8A; mem[8'h06] = 8'h3C;
      mem[8'h07] = 8'h02; mem[8'hFF] = 8'h90; mem[8'h40] = 8'h33;

      stepCycle(0, 0, 0, 0, 0, 8'h00);
      for (int id = 0; id <= ID_ERR; id++) expectLit(id, 8'h00);
      stepCycle(0, 0, 0, 0, 0, 8'h00);
      reset = 1'b1;

      // First instruction: one-byte 0x12 at address 0 after the pc_reset pulse.
      stepCycle(1, 0, 1, 0, 0, 8'h00);
      expectLit(ID_EN, 8'h01); expectLit(ID_RST, 8'h01); expectLit(ID_REQ, 8'h00);
      stepCycle(0, 0, 1, 0, 0, 8'h00);
      expectLit(ID_REQ, 8'h01); expectLit(ID_ADDR, 8'h00); expectLit(ID_EN, 8'h00);
      stepCycle(0, 0, 1, 0, 0, 8'h00);
      expectLit(ID_VALID, 8'h01); expectLit(ID_OP, 8'h12); expectLit(ID_IMM, 8'h00);
      expectLit(ID_EN, 8'h00); expectLit(ID_REQ, 8'h00);
      stepCycle(0, 0, 1, 1, 0, 8'h00);
      expectLit(ID_EN, 8'h01); expectLit(ID_INC, 8'h01); expectLit(ID_MODE, 8'h00);
      expectLit(ID_WR, 8'h00);
      stepCycle(0, 0, 1, 0, 0, 8'h00);
      expectLit(ID_ADDR, 8'h01); expectLit(ID_REQ, 8'h01);
      stepCycle(0, 0, 1, 0, 0, 8'h00);
      expectLit(ID_VALID, 8'h01); expectLit(ID_OP, 8'h01);
      stepCycle(0, 0, 1, 1, 1, 8'h05);
      expectLit(ID_WR, 8'h01); expectLit(ID_WV, 8'h05); expectLit(ID_INC, 8'h00);

      // Two-byte instruction at 0x05 with continuous request.
      stepCycle(0, 0, 1, 0, 0, 8'h00);
      expectLit(ID_REQ, 8'h01); expectLit(ID_ADDR, 8'h05);
      stepCycle(0, 0, 1, 0, 0, 8'h00);
      expectLit(ID_REQ, 8'h01); expectLit(ID_ADDR, 8'h06);
      stepCycle(0, 0, 1, 0, 0, 8'h00);
      expectLit(ID_VALID, 8'h01); expectLit(ID_OP, 8'h8A); expectLit(ID_IMM, 8'h3C);
      stepCycle(0, 0, 1, 1, 0, 8'h00);
      expectLit(ID_INC, 8'h01); expectLit(ID_MODE, 8'h01);
      stepCycle(0, 0, 1, 0, 0, 8'h00);
      expectLit(ID_ADDR, 8'h07);
      stepCycle(0, 0, 1, 0, 0, 8'h00);
      expectLit(ID_VALID, 8'h01); expectLit(ID_OP, 8'h02);
      stepCycle(0, 0, 1, 1, 1, 8'hFF);
      expectLit(ID_WR, 8'h01); expectLit(ID_WV, 8'hFF);

      // Op at 0xFF, immediate fetched from the wrapped address 0x00, then branch to 0x40.
      stepCycle(0, 0, 1, 0, 0, 8'h00);
      expectLit(ID_REQ, 8'h01); expectLit(ID_ADDR, 8'hFF);
      stepCycle(0, 0, 1, 0, 0, 8'h00);
      expectLit(ID_REQ, 8'h01); expectLit(ID_ADDR, 8'h00);
      stepCycle(0, 0, 1, 0, 0, 8'h00);
      expectLit(ID_OP, 8'h90); expectLit(ID_IMM, 8'h12);
      stepCycle(0, 0, 1, 1, 1, 8'h40);
      expectLit(ID_WR, 8'h01); expectLit(ID_WV, 8'h40); expectLit(ID_INC, 8'h00);
      stepCycle(0, 0, 1, 0, 0, 8'h00);
      expectLit(ID_ADDR, 8'h40);

      // Decode stall with a halt request in the middle of it.
      for (int i = 0; i < 5; i++) begin
         stepCycle(0, (i == 2), 1, 0, 0, 8'h00);
         expectLit(ID_VALID, 8'h01); expectLit(ID_OP, 8'h33); expectLit(ID_EN, 8'h00);
      end
      stepCycle(0, 0, 1, 1, 0, 8'h00);
      expectLit(ID_INC, 8'h01); expectLit(ID_MODE, 8'h00);
      stepCycle(0, 0, 1, 0, 0, 8'h00);
      expectLit(ID_HALTED, 8'h01); expectLit(ID_REQ, 8'h00);
      stepCycle(0, 0, 1, 0, 0, 8'h00);
      expectLit(ID_HALTED, 8'h01); expectLit(ID_EN, 8'h00);
      stepCycle(1, 0, 1, 0, 0, 8'h00);
      expectLit(ID_RST, 8'h00); expectLit(ID_EN, 8'h00); expectLit(ID_HALTED, 8'h01);

      // Resume at 0x41 with ack withheld: error after four request cycles.
      stepCycle(0, 0, 0, 0, 0, 8'h00);
      expectLit(ID_REQ, 8'h01); expectLit(ID_ADDR, 8'h41); expectLit(ID_HALTED, 8'h00);
      for (int i = 0; i < 3; i++) begin
         stepCycle(0, 0, 0, 0, 0, 8'h00);
         expectLit(ID_REQ, 8'h01); expectLit(ID_ERR, 8'h00);
      end
      stepCycle(0, 0, 0, 0, 0, 8'h00);
      expectLit(ID_ERR, 8'h01); expectLit(ID_REQ, 8'h00);
      stepCycle(1, 0, 0, 0, 0, 8'h00);
      expectLit(ID_ERR, 8'h01); expectLit(ID_EN, 8'h00); expectLit(ID_RST, 8'h00);
      stepCycle(0, 0, 0, 0, 0, 8'h00);
      reset = 1'b0;
      expectLit(ID_ERR, 8'h00);
      stepCycle(0, 0, 0, 0, 0, 8'h00);
      reset = 1'b1;

      // Ack arriving in the last allowed request cycle is accepted.
      stepCycle(1, 0, 0, 0, 0, 8'h00);
      expectLit(ID_RST, 8'h01);
      stepCycle(0, 0, 0, 0, 0, 8'h00);
      expectLit(ID_REQ, 8'h01); expectLit(ID_ADDR, 8'h00);
      for (int i = 0; i < 2; i++) begin
         stepCycle(0, 0, 0, 0, 0, 8'h00);
         expectLit(ID_REQ, 8'h01); expectLit(ID_ERR, 8'h00);
      end
      stepCycle(0, 0, 1, 0, 0, 8'h00);
      expectLit(ID_REQ, 8'h01); expectLit(ID_ERR, 8'h00);
      stepCycle(0, 0, 0, 0, 0, 8'h00);
      expectLit(ID_VALID, 8'h01); expectLit(ID_OP, 8'h12); expectLit(ID_ERR, 8'h00);

      // Asynchronous reset while fetching the immediate byte.
      stepCycle(0, 0, 1, 1, 1, 8'hFF);
      expectLit(ID_WR, 8'h01); expectLit(ID_WV, 8'hFF);
      stepCycle(0, 0, 1, 0, 0, 8'h00);
      expectLit(ID_ADDR, 8'hFF);
      stepCycle(0, 0, 0, 0, 0, 8'h00);
      expectLit(ID_REQ, 8'h01); expectLit(ID_ADDR, 8'h00);
      @(negedge clk);
      #2;
      reset = 1'b0;
      #1;
      expectLit(ID_REQ, 8'h00); expectLit(ID_ADDR, 8'h00); expectLit(ID_VALID, 8'h00);
      expectLit(ID_OP, 8'h00); expectLit(ID_IMM, 8'h00); expectLit(ID_EN, 8'h00);
      expectLit(ID_HALTED, 8'h00); expectLit(ID_ERR, 8'h00);
      probe = 1'b1;
      #1;
      probe = 1'b0;
      stepCycle(0, 0, 0, 0, 0, 8'h00);
      expectLit(ID_REQ, 8'h00);
      stepCycle(0, 0, 0, 0, 0, 8'h00);
      reset = 1'b1;
      stepCycle(0, 0, 1, 0, 0, 8'h00);
      expectLit(ID_REQ, 8'h00); expectLit(ID_EN, 8'h00); expectLit(ID_ERR, 8'h00);
      stepCycle(0, 0, 1, 0, 0, 8'h00);
      expectLit(ID_REQ, 8'h00);

      // Randomized traffic; errors and occasional random resets are recovered by reset.
      for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
      errCycles = 0;
      inReset = 0;
      for (int n = 0; n < 4000; n++) begin
         @(posedge clk);
         #1;
         errCycles = err ? errCycles + 1 : 0;
         if (inReset == 0 && (errCycles > 2 || $urandom_range(0, 399) == 0)) inReset = 2;
         if (inReset > 0) begin
            reset = 1'b0;
            inReset--;
            errCycles = 0;
         end else begin
            reset = 1'b1;
         end
         applyStimulus($urandom_range(0, 5) == 0, $urandom_range(0, 19) == 0,
                       $urandom_range(0, 9) < 6, $urandom_range(0, 1) == 1,
                       $urandom_range(0, 9) < 3, 8'($urandom));
      end
      reset = 1'b1;
      stepCycle(0, 0, 0, 0, 0, 8'h00);
      stepCycle(0, 0, 0, 0, 0, 8'h00);
      @(negedge clk);
      #1;
      $display("test done: total=%0d bad=%0d", totalCount, badCount);
      $finish;
   end

endmodule
